mem_arbiter: RTL and testbench

- Shares one single-port unified memory between the instruction-fetch port and the load/store data port.
- Used when the core moves from split instruction/data memories to one memory.
- Sequences each access as: arbitrate, issue, wait for fixed memory latency, respond.
- Exposes req/gnt/rvalid handshakes so the PC and load/store logic can stall on them.

---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/mem_arbiter_rr_arb2.sv | 25 ++
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared state encoding, requester ids and counter width for mem_arbiter
package mem_arbiter_pkg;

   // Access sequencing states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_WAIT   = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   // Requester ids; also the bit positions in the arbiter request vector
   localparam logic REQ_IF = 1'b0;
   localparam logic REQ_D  = 1'b1;

   // Width of the memory latency down-counter (MEM_LAT up to 15)
   localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rtl/mem_arbiter_rr_arb2.sv - combinational two-way round-robin picker
module rr_arb2
   import mem_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] grant,
   output logic       grant_id
);

   // A lone requester wins; on a tie the port that did not win last time goes first
   always_comb begin
      grant_id = REQ_IF;
      grant    = 2'b00;
      if (req == 2'b11) begin
         grant_id = (last == REQ_IF) ? REQ_D : REQ_IF;
      end else if (req[REQ_D]) begin
         grant_id = REQ_D;
      end
      if (req != 2'b00) begin
         grant[grant_id] = 1'b1;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one single-port memory between the fetch port and the load/store port
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 1
)
(
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_gnt,
   output logic                if_rvalid,
   output logic [DATA_W-1:0]   if_rdata,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_be,
   output logic                d_gnt,
   output logic                d_rvalid,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                mem_en,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_be,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                busy
);

   localparam int BE_W = DATA_W / 8;
   localparam logic [CNT_W-1:0] LAT_M1 = 4'(MEM_LAT - 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              id_q, id_d;
   logic              we_q, we_d;
   logic              last_q, last_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [BE_W-1:0]   be_q, be_d;

   logic              arb_open;
   logic [1:0]        arb_req;
   logic [1:0]        arb_grant;
   logic              arb_id;

   assign arb_req = {d_req, if_req};

   rr_arb2 u_rr_arb2 (
      .req      (arb_req),
      .last     (last_q),
      .grant    (arb_grant),
      .grant_id (arb_id)
   );

   // Next state, latency countdown and winner latch; requests are only looked at in IDLE and RESP
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      id_d     = id_q;
      we_d     = we_q;
      last_d   = last_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      be_d     = be_q;
      arb_open = 1'b0;

      case (state_q)
         ST_IDLE: begin
            arb_open = 1'b1;
         end
         ST_ACCESS: begin
            cnt_d   = LAT_M1;
            state_d = (MEM_LAT == 1) ? ST_RESP : ST_WAIT;
         end
         ST_WAIT: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_d == '0) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            arb_open = 1'b1;
            state_d  = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (arb_open && (arb_grant != 2'b00)) begin
         state_d = ST_ACCESS;
         id_d    = arb_id;
         last_d  = arb_id;
         if (arb_id == REQ_D) begin
            addr_d  = d_addr;
            we_d    = d_we;
            wdata_d = d_wdata;
            be_d    = d_be;
         end else begin
            // Fetches are always full-word reads
            addr_d  = if_addr;
            we_d    = 1'b0;
            wdata_d = '0;
            be_d    = '1;
         end
      end
   end

   // State and latch registers; reset drops any in-flight access and biases the first tie to data
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         id_q    <= REQ_IF;
         we_q    <= 1'b0;
         last_q  <= REQ_IF;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         id_q    <= id_d;
         we_q    <= we_d;
         last_q  <= last_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
      end
   end

   assign mem_en    = (state_q == ST_ACCESS);
   assign mem_we    = mem_en & we_q;
   assign mem_addr  = mem_en ? addr_q  : '0;
   assign mem_wdata = mem_en ? wdata_q : '0;
   assign mem_be    = mem_en ? be_q    : '0;

   assign if_gnt    = mem_en & (id_q == REQ_IF);
   assign d_gnt     = mem_en & (id_q == REQ_D);

   assign if_rvalid = (state_q == ST_RESP) & (id_q == REQ_IF);
   assign d_rvalid  = (state_q == ST_RESP) & (id_q == REQ_D);
   assign if_rdata  = if_rvalid ? mem_rdata : '0;
   assign d_rdata   = (d_rvalid && !we_q) ? mem_rdata : '0;

   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with MEM_LAT=1 and MEM_LAT=3 instances
module tb_mem_arbiter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [1:0]  if_req, d_req, d_we;
   logic [31:0] if_addr [2];
   logic [31:0] d_addr [2];
   logic [31:0] d_wdata [2];
   logic [3:0]  d_be [2];
   logic [1:0]  if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
   logic [31:0] if_rdata [2];
   logic [31:0] d_rdata [2];
   logic [31:0] mem_addr [2];
   logic [31:0] mem_wdata [2];
   logic [31:0] mem_rdata [2];
   logic [3:0]  mem_be [2];

   function automatic logic [31:0] data_of(input logic [31:0] a);
      return a ^ 32'h0050_0103;
   endfunction

   for (genvar k = 0; k < 2; k++) begin : g_dut
      localparam int LAT = (k == 0) ? 1 : 3;
      logic [31:0] pipe [3];

      mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .if_req    (if_req[k]),
         .if_addr   (if_addr[k]),
         .if_gnt    (if_gnt[k]),
         .if_rvalid (if_rvalid[k]),
         .if_rdata  (if_rdata[k]),
         .d_req     (d_req[k]),
         .d_we      (d_we[k]),
         .d_addr    (d_addr[k]),
         .d_wdata   (d_wdata[k]),
         .d_be      (d_be[k]),
         .d_gnt     (d_gnt[k]),
         .d_rvalid  (d_rvalid[k]),
         .d_rdata   (d_rdata[k]),
         .mem_en    (mem_en[k]),
         .mem_we    (mem_we[k]),
         .mem_addr  (mem_addr[k]),
         .mem_wdata (mem_wdata[k]),
         .mem_be    (mem_be[k]),
         .mem_rdata (mem_rdata[k]),
         .busy      (busy[k])
      );

      // Memory model: read data appears exactly LAT cycles after mem_en, filler otherwise
      always @(posedge clk) begin
         pipe[0] <= (mem_en[k] && !mem_we[k]) ? data_of(mem_addr[k]) : 32'hA5A5_5A5A;
         pipe[1] <= pipe[0];
         pipe[2] <= pipe[1];
      end
      assign mem_rdata[k] = pipe[LAT-1];
   end

   typedef struct packed {
      logic        dut;
      logic        port;
      logic [31:0] data;
      logic [31:0] due;
   } exp_t;
   exp_t sbq [$];

   typedef struct {
      logic        ireq, dreq, dwe;
      logic [31:0] iaddr, daddr, dwdata;
      logic [3:0]  dbe;
      logic [5:0]  ectrl;
      logic [31:0] emaddr, erdata;
   } vec_t;
   vec_t tbl [$];

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic monitor();
      exp_t e;
      for (int k = 0; k < 2; k++) begin
         int lat;
         lat = (k == 0) ? 1 : 3;
         chk($sformatf("overlap%0d", k),
             {if_gnt[k] & d_gnt[k], if_rvalid[k] & d_rvalid[k], if_gnt[k] & if_rvalid[k], d_gnt[k] & d_rvalid[k]}, 0);
         chk($sformatf("rdata_idle%0d", k),
             {(if_rvalid[k] ? 32'h0 : if_rdata[k]), (d_rvalid[k] ? 32'h0 : d_rdata[k])}, 0);
         if (if_gnt[k]) begin
            chk($sformatf("if_issue%0d", k), {mem_addr[k], mem_we[k], mem_be[k]}, {if_addr[k], 1'b0, 4'hF});
            e.dut = k[0]; e.port = 1'b0; e.data = data_of(if_addr[k]); e.due = 32'(cyc + lat);
            sbq.push_back(e);
         end
         if (d_gnt[k]) begin
            chk($sformatf("d_issue%0d", k), {mem_addr[k], mem_we[k], mem_be[k]}, {d_addr[k], d_we[k], d_be[k]});
            if (d_we[k]) chk($sformatf("d_wdata%0d", k), mem_wdata[k], d_wdata[k]);
            e.dut = k[0]; e.port = 1'b1; e.data = d_we[k] ? 32'h0 : data_of(d_addr[k]); e.due = 32'(cyc + lat);
            sbq.push_back(e);
         end
         if (if_rvalid[k] || d_rvalid[k]) begin
            if (sbq.size() == 0) begin
               chk($sformatf("unexpected_rvalid%0d", k), {if_rvalid[k], d_rvalid[k]}, 0);
            end else begin
               e = sbq.pop_front();
               chk("rsp_dut", k, e.dut);
               chk("rsp_port", d_rvalid[k], e.port);
               chk("rsp_data", d_rvalid[k] ? d_rdata[k] : if_rdata[k], e.data);
               chk("rsp_cycle", cyc, e.due);
            end
         end
      end
      if (rst) sbq.delete();
   endtask

   task automatic sample();
      @(negedge clk);
      cyc++;
      monitor();
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   task automatic cycle();
      sample();
      advance();
   endtask

   task automatic check_quiet(input int k, input string tag);
      chk({tag, "_ctrl"}, {if_gnt[k], d_gnt[k], if_rvalid[k], d_rvalid[k], mem_en[k], mem_we[k], busy[k]}, 0);
      chk({tag, "_data"}, if_rdata[k] | d_rdata[k] | mem_addr[k] | mem_wdata[k], 0);
      chk({tag, "_be"}, mem_be[k], 0);
   endtask

   task automatic row(input logic ireq, input logic dreq, input logic dwe,
                      input logic [31:0] iaddr, input logic [31:0] daddr, input logic [31:0] dwdata,
                      input logic [3:0] dbe, input logic [5:0] ectrl,
                      input logic [31:0] emaddr, input logic [31:0] erdata);
      vec_t v;
      v.ireq = ireq; v.dreq = dreq; v.dwe = dwe;
      v.iaddr = iaddr; v.daddr = daddr; v.dwdata = dwdata; v.dbe = dbe;
      v.ectrl = ectrl; v.emaddr = emaddr; v.erdata = erdata;
      tbl.push_back(v);
   endtask

   // Both ports request continuously; grants must alternate starting with the data port
   task automatic contend(input int k, input int want, input string tag);
      int got = 0;
      int n = 0;
      int nd = 0;
      logic gi, gd;
      if_addr[k] = 32'h2000; d_addr[k] = 32'h1000; d_we[k] = 1'b0; d_be[k] = 4'hF;
      if_req[k] = 1'b1; d_req[k] = 1'b1;
      while (got < want && n < 100) begin
         sample();
         gi = if_gnt[k];
         gd = d_gnt[k];
         if (gi || gd) begin
            chk($sformatf("%s_grant%0d_is_d", tag, got), gd, (got % 2 == 0));
            if (gd) nd++;
            got++;
         end
         advance();
         if (gi) if_addr[k] = if_addr[k] + 32'd4;
         if (gd) d_addr[k] = d_addr[k] + 32'd8;
         if (got == want) begin
            if_req[k] = 1'b0;
            d_req[k] = 1'b0;
         end
         n++;
      end
      chk({tag, "_count"}, got, want);
      chk({tag, "_d_share"}, nd, want / 2);
      repeat (8) cycle();
   endtask

   localparam logic [5:0] C_IDLE = 6'b000000;
   localparam logic [5:0] C_IACC = 6'b100011;
   localparam logic [5:0] C_DACC = 6'b010011;
   localparam logic [5:0] C_IRSP = 6'b001001;
   localparam logic [5:0] C_DRSP = 6'b000101;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int ngnt, n, last_en;
      logic g;

      // MEM_LAT=1 cycle table: fetch, tie, store, re-assert in RESP, req dropped before sampling
      row(1, 0, 0, 32'h10, 0, 0, 0, C_IDLE, 0, 0);
      row(1, 0, 0, 32'h10, 0, 0, 0, C_IACC, 32'h10, 0);
      row(0, 0, 0, 0, 0, 0, 0, C_IRSP, 0, 32'h0050_0113);
      row(0, 0, 0, 0, 0, 0, 0, C_IDLE, 0, 0);
      row(1, 1, 0, 32'h20, 32'h40, 0, 4'hF, C_IDLE, 0, 0);
      row(1, 1, 0, 32'h20, 32'h40, 0, 4'hF, C_DACC, 32'h40, 0);
      row(1, 0, 0, 32'h20, 0, 0, 0, C_DRSP, 0, 32'h0050_0143);
      row(1, 0, 0, 32'h20, 0, 0, 0, C_IACC, 32'h20, 0);
      row(0, 0, 0, 0, 0, 0, 0, C_IRSP, 0, 32'h0050_0123);
      row(0, 0, 0, 0, 0, 0, 0, C_IDLE, 0, 0);
      row(0, 1, 1, 0, 32'h80, 32'hDEAD_BEEF, 4'b0011, C_IDLE, 0, 0);
      row(0, 1, 1, 0, 32'h80, 32'hDEAD_BEEF, 4'b0011, C_DACC, 32'h80, 0);
      row(0, 0, 0, 0, 0, 0, 0, C_DRSP, 0, 0);
      row(0, 0, 0, 0, 0, 0, 0, C_IDLE, 0, 0);
      row(1, 0, 0, 32'h30, 0, 0, 0, C_IDLE, 0, 0);
      row(1, 0, 0, 32'h30, 0, 0, 0, C_IACC, 32'h30, 0);
      row(1, 0, 0, 32'h34, 0, 0, 0, C_IRSP, 0, 32'h0050_0133);
      row(1, 1, 0, 32'h34, 32'h50, 0, 4'hF, C_IACC, 32'h34, 0);
      row(0, 0, 0, 0, 0, 0, 0, C_IRSP, 0, 32'h0050_0137);
      row(0, 0, 0, 0, 0, 0, 0, C_IDLE, 0, 0);

      rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         if_req[k] = 1'b0; d_req[k] = 1'b0; d_we[k] = 1'b0;
         if_addr[k] = '0; d_addr[k] = '0; d_wdata[k] = '0; d_be[k] = '0;
      end
      cycle();
      sample();
      check_quiet(0, "reset0");
      check_quiet(1, "reset1");
      advance();
      rst = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         if_req[0] = tbl[i].ireq; d_req[0] = tbl[i].dreq; d_we[0] = tbl[i].dwe;
         if_addr[0] = tbl[i].iaddr; d_addr[0] = tbl[i].daddr;
         d_wdata[0] = tbl[i].dwdata; d_be[0] = tbl[i].dbe;
         sample();
         chk($sformatf("vec%0d_ctrl", i),
             {if_gnt[0], d_gnt[0], if_rvalid[0], d_rvalid[0], mem_en[0], busy[0]}, tbl[i].ectrl);
         chk($sformatf("vec%0d_mem_addr", i), mem_addr[0], tbl[i].emaddr);
         chk($sformatf("vec%0d_rdata", i), if_rdata[0] | d_rdata[0], tbl[i].erdata);
         advance();
      end

      // MEM_LAT=3, continuous fetch: one access every 4 cycles
      if_addr[1] = 32'h100; if_req[1] = 1'b1;
      ngnt = 0; n = 0; last_en = -1;
      while (ngnt < 4 && n < 40) begin
         sample();
         if (mem_en[1]) begin
            if (last_en >= 0) chk("lat3_en_period", cyc - last_en, 4);
            last_en = cyc;
         end
         g = if_gnt[1];
         if (g) ngnt++;
         advance();
         if (g) if_addr[1] = if_addr[1] + 32'd4;
         if (ngnt == 4) if_req[1] = 1'b0;
         n++;
      end
      chk("lat3_grants", ngnt, 4);
      repeat (6) cycle();
      chk("lat3_drained", sbq.size(), 0);

      // MEM_LAT=3, reset during WAIT drops the access
      if_addr[1] = 32'h200; if_req[1] = 1'b1;
      sample(); chk("mid_rst_idle", busy[1], 0); advance();
      sample(); chk("mid_rst_gnt", if_gnt[1], 1); advance();
      if_req[1] = 1'b0;
      sample(); chk("mid_rst_wait", {busy[1], mem_en[1], if_rvalid[1]}, 3'b100); advance();
      rst = 1'b1;
      sample(); advance();
      rst = 1'b0;
      sample(); check_quiet(1, "mid_rst_after"); advance();
      repeat (4) cycle();
      contend(1, 2, "tie_after_rst");

      // Fairness on MEM_LAT=1 from a fresh reset
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      contend(0, 10, "fair");

      repeat (4) cycle();
      chk("sb_empty", sbq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
